// File: rtl/design_1_if.sv
// Front-panel I/O bundle: switches and keys in, LED and seven-segment drive out.
// The board (or bench) takes the master side; the panel logic takes the slave side.
interface design_1_if;
   logic [9:0] switch;
   logic [1:0] key;
   logic [9:0] leds;
   logic [7:0] hex0;
   logic [7:0] hex1;
   logic [7:0] hex2;
   logic [7:0] hex3;
   logic [7:0] hex4;
   logic [7:0] hex5;

   modport master (
      output switch, key,
      input  leds, hex0, hex1, hex2, hex3, hex4, hex5
   );

   modport slave (
      input  switch, key,
      output leds, hex0, hex1, hex2, hex3, hex4, hex5
   );
endinterface

// File: rtl/design_1.sv
// Front-panel controller: LEDs mirror the switches (key 0 inverts), displays show
// the switch value in hex or, while key 1 is held, a fixed birthday date.
module design_1 #(
   parameter logic [23:0] BIRTHDAY = 24'h041299,
   parameter logic [5:0]  BDAY_DP  = 6'b010100
) (
   input logic        clk,
   input logic        rst_n,
   design_1_if.slave  io
);

   logic [9:0]      swMeta;
   logic [9:0]      swSync;
   logic [1:0]      keyMeta;
   logic [1:0]      keySync;
   logic [9:0]      ledsReg;
   logic [5:0][7:0] hexReg;
   logic [5:0][7:0] hexNext;

   // Active-low seven-segment glyph for one nibble, decimal point off.
   function automatic logic [7:0] glyph(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

   // Two-flop synchronizers; switches and keys are both asynchronous to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         swMeta  <= '0;
         swSync  <= '0;
         keyMeta <= '0;
         keySync <= '0;
      end else begin
         swMeta  <= io.switch;
         swSync  <= swMeta;
         keyMeta <= io.key;
         keySync <= keyMeta;
      end
   end

   // Display content selection; key 1 swaps in the birthday with its dots lit.
   always_comb begin
      hexNext = {6{8'hFF}};
      if (keySync[1]) begin
         for (int i = 0; i < 6; i++) begin
            hexNext[i] = glyph(BIRTHDAY[4*i +: 4]);
            if (BDAY_DP[i]) begin
               hexNext[i][7] = 1'b0;
            end
         end
      end else begin
         hexNext[0] = glyph(swSync[3:0]);
         hexNext[1] = glyph(swSync[7:4]);
         hexNext[2] = glyph({2'b00, swSync[9:8]});
      end
   end

   // Registered outputs keep the panel drive glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ledsReg <= '0;
         hexReg  <= {6{8'hFF}};
      end else begin
         ledsReg <= swSync ^ {10{keySync[0]}};
         hexReg  <= hexNext;
      end
   end

   assign io.leds = ledsReg;
   assign io.hex0 = hexReg[0];
   assign io.hex1 = hexReg[1];
   assign io.hex2 = hexReg[2];
   assign io.hex3 = hexReg[3];
   assign io.hex4 = hexReg[4];
   assign io.hex5 = hexReg[5];

endmodule

// File: tb/tb_design_1.sv
// Self-checking bench for the front-panel controller: expectations are queued
// when inputs are driven and compared once the synchronizer latency has elapsed.
module tb_design_1;

   localparam logic [23:0] BDAY = 24'h041299;
   localparam logic [5:0]  BDP  = 6'b010100;

   typedef struct packed {
      logic [9:0]  leds;
      logic [47:0] hex;
   } expT;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   design_1_if bus();

   design_1 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus)
   );

   expT scoreboard[$];
   int  checkCount = 0;
   int  passCount  = 0;

   logic [7:0] glyphTab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Reference model of what the panel should show for a given input setting.
   function automatic expT model(input logic [9:0] sw, input logic [1:0] k);
      expT        e;
      logic [3:0] nib;
      logic [7:0] g;
      e.leds = sw ^ {10{k[0]}};
      if (k[1]) begin
         e.hex = '0;
         for (int i = 0; i < 6; i++) begin
            nib = BDAY[4*i +: 4];
            g   = glyphTab[nib];
            if (BDP[i]) g[7] = 1'b0;
            e.hex[8*i +: 8] = g;
         end
      end else begin
         e.hex = {24'hFFFFFF, glyphTab[{2'b00, sw[9:8]}], glyphTab[sw[7:4]], glyphTab[sw[3:0]]};
      end
      return e;
   endfunction

   function automatic logic [47:0] readHex();
      return {bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
   endfunction

   task applyStimulus(input logic [9:0] sw, input logic [1:0] k);
      bus.switch = sw;
      bus.key    = k;
      scoreboard.push_back(model(sw, k));
   endtask

   // Inputs change on a falling edge; three rising edges later the outputs must track.
   task settle();
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   task test_reset();
      expT exp;
      bus.switch = 10'h3FF;
      bus.key    = 2'b11;
      rst_n      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkCount++;
      if (bus.leds !== 10'h000) $display("[TB] FAIL reset_leds: got %h, expected %h", bus.leds, 10'h000);
      else passCount++;
      checkCount++;
      if (readHex() !== {6{8'hFF}}) $display("[TB] FAIL reset_hex: got %h, expected %h", readHex(), {6{8'hFF}});
      else passCount++;
      rst_n = 1'b1;
      applyStimulus(10'h3FF, 2'b11);
      settle();
      exp = scoreboard.pop_front();
      checkCount++;
      if (bus.leds !== exp.leds) $display("[TB] FAIL post_reset_leds: got %h, expected %h", bus.leds, exp.leds);
      else passCount++;
      checkCount++;
      if (readHex() !== 48'hC019F9249090) $display("[TB] FAIL post_reset_bday: got %h, expected %h", readHex(), 48'hC019F9249090);
      else passCount++;
   endtask

   task test_switches();
      logic [9:0] pats [4] = '{10'h005, 10'h3FF, 10'h2A5, 10'h130};
      expT exp;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(pats[i], 2'b00);
         settle();
         exp = scoreboard.pop_front();
         checkCount++;
         if (bus.leds !== exp.leds) $display("[TB] FAIL switches_leds[%0d]: got %h, expected %h", i, bus.leds, exp.leds);
         else passCount++;
         checkCount++;
         if (readHex() !== exp.hex) $display("[TB] FAIL switches_hex[%0d]: got %h, expected %h", i, readHex(), exp.hex);
         else passCount++;
      end
      applyStimulus(10'h005, 2'b00);
      settle();
      exp = scoreboard.pop_front();
      checkCount++;
      if (readHex() !== 48'hFFFFFFC0C092) $display("[TB] FAIL switches_hex_005: got %h, expected %h", readHex(), 48'hFFFFFFC0C092);
      else passCount++;
   endtask

   task test_led_invert();
      expT exp;
      applyStimulus(10'h005, 2'b01);
      settle();
      exp = scoreboard.pop_front();
      checkCount++;
      if (bus.leds !== 10'h3FA) $display("[TB] FAIL invert_leds: got %h, expected %h", bus.leds, 10'h3FA);
      else passCount++;
      checkCount++;
      if (readHex() !== exp.hex) $display("[TB] FAIL invert_hex: got %h, expected %h", readHex(), exp.hex);
      else passCount++;
      applyStimulus(10'h005, 2'b00);
      settle();
      exp = scoreboard.pop_front();
      checkCount++;
      if (bus.leds !== exp.leds) $display("[TB] FAIL invert_release: got %h, expected %h", bus.leds, exp.leds);
      else passCount++;
   endtask

   task test_birthday();
      expT exp;
      applyStimulus(10'h1C3, 2'b10);
      settle();
      exp = scoreboard.pop_front();
      checkCount++;
      if (readHex() !== 48'hC019F9249090) $display("[TB] FAIL bday_hex: got %h, expected %h", readHex(), 48'hC019F9249090);
      else passCount++;
      checkCount++;
      if (bus.leds !== exp.leds) $display("[TB] FAIL bday_leds: got %h, expected %h", bus.leds, exp.leds);
      else passCount++;
      applyStimulus(10'h1C3, 2'b00);
      settle();
      exp = scoreboard.pop_front();
      checkCount++;
      if (readHex() !== exp.hex) $display("[TB] FAIL bday_release: got %h, expected %h", readHex(), exp.hex);
      else passCount++;
   endtask

   task test_sweep();
      expT exp;
      for (int v = 0; v < 256; v++) begin
         applyStimulus(v[9:0], 2'b00);
         @(posedge clk);
         settle();
         exp = scoreboard.pop_front();
         checkCount++;
         if (bus.leds !== exp.leds) $display("[TB] FAIL sweep_leds[%0d]: got %h, expected %h", v, bus.leds, exp.leds);
         else passCount++;
         checkCount++;
         if ({bus.hex1, bus.hex0} !== exp.hex[15:0])
            $display("[TB] FAIL sweep_hex[%0d]: got %h, expected %h", v, {bus.hex1, bus.hex0}, exp.hex[15:0]);
         else passCount++;
      end
   endtask

   task test_simultaneous();
      expT exp;
      applyStimulus(10'h2A5, 2'b11);
      settle();
      exp = scoreboard.pop_front();
      checkCount++;
      if (bus.leds !== 10'h15A) $display("[TB] FAIL both_leds: got %h, expected %h", bus.leds, 10'h15A);
      else passCount++;
      checkCount++;
      if (readHex() !== exp.hex) $display("[TB] FAIL both_hex: got %h, expected %h", readHex(), exp.hex);
      else passCount++;
      #3 rst_n = 1'b0;
      #1;
      checkCount++;
      if (bus.leds !== 10'h000) $display("[TB] FAIL midreset_leds: got %h, expected %h", bus.leds, 10'h000);
      else passCount++;
      checkCount++;
      if (readHex() !== {6{8'hFF}}) $display("[TB] FAIL midreset_hex: got %h, expected %h", readHex(), {6{8'hFF}});
      else passCount++;
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(10'h2A5, 2'b11);
      settle();
      exp = scoreboard.pop_front();
      checkCount++;
      if (bus.leds !== exp.leds) $display("[TB] FAIL rereset_leds: got %h, expected %h", bus.leds, exp.leds);
      else passCount++;
      checkCount++;
      if (readHex() !== exp.hex) $display("[TB] FAIL rereset_hex: got %h, expected %h", readHex(), exp.hex);
      else passCount++;
   endtask

   initial begin
      bus.switch = '0;
      bus.key    = '0;
      @(negedge clk);
      test_reset();
      test_switches();
      test_led_invert();
      test_birthday();
      test_sweep();
      test_simultaneous();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
